adsr_envelope: RTL and testbench

- Per-voice ADSR envelope generator and amplitude scaler sitting directly downstream of the sequential voice generator.
- Consumes one signed raw waveform sample per voice update, advances that voice's envelope state, and emits the scaled sample, tagged with its voice number, toward the mixer/filter.
- Voices are time-multiplexed. The controller presents gate and ADSR nibbles for the voice on act_voice_i, the same way it presents frequency words to the voice generator.

---
 rtl/adsr_pkg.sv | 41 ++++
 rtl/adsr_envelope_if.sv | 38 +++
 rtl/adsr_envelope_scale.sv | 22 ++
 rtl/adsr_envelope.sv | 153 +++++++++++++++
 tb/tb_adsr_envelope.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/adsr_pkg.sv
// Shared types and constants for the per-voice ADSR envelope generator.
// ENV_EXP_DECAY_EN widens the rate counter and adds the exponential decay/release factor.
package adsr_pkg;

   typedef enum logic [1:0] {
      ST_RELEASE = 2'd0,
      ST_ATTACK  = 2'd1,
      ST_DECAY   = 2'd2,
      ST_SUSTAIN = 2'd3
   } env_state_e;

   localparam logic [7:0] ENV_MAX = 8'd255;

   localparam logic [15:0] RATE_PERIOD [16] = '{
      16'd1,   16'd2,   16'd4,    16'd6,    16'd9,    16'd14,   16'd17,   16'd20,
      16'd25,  16'd61,  16'd122,  16'd196,  16'd245,  16'd735,  16'd1225, 16'd1960
   };

`ifdef ENV_EXP_DECAY_EN
   localparam int CNT_W = 23;

   // Lower bound of each env band and the period multiplier applied inside that band.
   localparam logic [7:0] EXP_T1 = 8'd94;
   localparam logic [7:0] EXP_T2 = 8'd55;
   localparam logic [7:0] EXP_T3 = 8'd27;
   localparam logic [7:0] EXP_T4 = 8'd15;
   localparam logic [7:0] EXP_T5 = 8'd7;

   function automatic logic [4:0] exp_factor(input logic [7:0] env);
      if (env >= EXP_T1)      return 5'd1;
      else if (env >= EXP_T2) return 5'd2;
      else if (env >= EXP_T3) return 5'd4;
      else if (env >= EXP_T4) return 5'd8;
      else if (env >= EXP_T5) return 5'd16;
      else                    return 5'd30;
   endfunction
`else
   localparam int CNT_W = 18;
`endif

endpackage

// File: rtl/adsr_envelope_if.sv
// Bus between the controller/voice generator and the ADSR envelope block.
// Uses ENV_EXP_DECAY_EN indirectly through adsr_pkg only.
interface adsr_envelope_if #(
   parameter int WAVE_W = 10,
   parameter int ENV_W  = 8
);
   import adsr_pkg::*;

   // wave_valid_i is a one-cycle strobe with no back-pressure: every asserted cycle
   // is one update of act_voice_i, answered one cycle later by sample_valid_o.
   logic                     wave_valid_i;
   logic [1:0]               act_voice_i;
   logic signed [WAVE_W-1:0] wave_i;
   logic                     gate_i;
   logic [3:0]               attack_i;
   logic [3:0]               decay_i;
   logic [3:0]               sustain_i;
   logic [3:0]               release_i;

   logic                     sample_valid_o;
   logic [1:0]               sample_voice_o;
   logic signed [WAVE_W-1:0] sample_o;
   logic [ENV_W-1:0]         env_o;
   env_state_e               dbg_state;

   modport master (
      output wave_valid_i, act_voice_i, wave_i, gate_i,
             attack_i, decay_i, sustain_i, release_i,
      input  sample_valid_o, sample_voice_o, sample_o, env_o, dbg_state
   );

   modport slave (
      input  wave_valid_i, act_voice_i, wave_i, gate_i,
             attack_i, decay_i, sustain_i, release_i,
      output sample_valid_o, sample_voice_o, sample_o, env_o, dbg_state
   );

endinterface

// File: rtl/adsr_envelope_scale.sv
// Combinational signed-sample by unsigned-envelope multiply, floored by >>> ENV_W.
module adsr_scale #(
   parameter int WAVE_W = 10,
   parameter int ENV_W  = 8
) (
   input  logic signed [WAVE_W-1:0] wave_i,
   input  logic [ENV_W-1:0]         env_i,
   output logic signed [WAVE_W-1:0] sample_o
);

   localparam int P_W = WAVE_W + ENV_W + 1;

   logic signed [P_W-1:0] wave_x;
   logic signed [P_W-1:0] env_x;
   logic signed [P_W-1:0] product;

   assign wave_x   = P_W'(wave_i);
   assign env_x    = $signed(P_W'({1'b0, env_i}));
   assign product  = wave_x * env_x;
   assign sample_o = WAVE_W'(product >>> ENV_W);

endmodule

// File: rtl/adsr_envelope.sv
// Time-multiplexed ADSR envelope generator and amplitude scaler, one update per wave strobe.
// ENV_EXP_DECAY_EN selects the exponential decay/release curve; undefined gives linear.
module adsr_envelope
   import adsr_pkg::*;
#(
   parameter int NUM_VOICES = 3,
   parameter int WAVE_W     = 10,
   parameter int ENV_W      = 8
) (
   input logic             clk_i,
   input logic             rst_i,
   adsr_envelope_if.slave  bus
);

   logic [ENV_W-1:0] env_q  [NUM_VOICES];
   env_state_e       st_q   [NUM_VOICES];
   logic [CNT_W-1:0] cnt_q  [NUM_VOICES];
   logic             gate_q [NUM_VOICES];

   logic             upd;
   logic [1:0]       vidx;
   logic [ENV_W-1:0] env_cur, env_d;
   env_state_e       st_cur, st_d;
   logic [CNT_W-1:0] cnt_cur, cnt_d, cnt_inc;
   logic             gate_cur;
   logic             rise, fall, tick;
   logic [7:0]       sus_lvl;
   logic [3:0]       dr_idx;
   logic [CNT_W-1:0] p_one, p_three, p_dr, period;
   logic signed [WAVE_W-1:0] scaled;

   assign upd  = bus.wave_valid_i && (int'(bus.act_voice_i) < NUM_VOICES);
   assign vidx = upd ? bus.act_voice_i : 2'd0;

   assign env_cur  = env_q[vidx];
   assign st_cur   = st_q[vidx];
   assign cnt_cur  = cnt_q[vidx];
   assign gate_cur = gate_q[vidx];

   assign rise    = bus.gate_i & ~gate_cur;
   assign fall    = ~bus.gate_i & gate_cur;
   assign sus_lvl = {bus.sustain_i, bus.sustain_i};

   // Decay and release share the same tripled table period; attack uses the table directly.
   assign dr_idx  = (st_cur == ST_RELEASE) ? bus.release_i : bus.decay_i;
   assign p_one   = CNT_W'(RATE_PERIOD[dr_idx]);
   assign p_three = (p_one << 1) + p_one;
`ifdef ENV_EXP_DECAY_EN
   assign p_dr    = p_three * CNT_W'(exp_factor(env_cur));
`else
   assign p_dr    = p_three;
`endif
   assign period  = (st_cur == ST_ATTACK) ? CNT_W'(RATE_PERIOD[bus.attack_i]) : p_dr;
   assign cnt_inc = cnt_cur + CNT_W'(1);
   assign tick    = ({1'b0, cnt_cur} + (CNT_W+1)'(1)) >= {1'b0, period};

   always_comb begin
      env_d = env_cur;
      st_d  = st_cur;
      cnt_d = cnt_cur;
      if (rise) begin
         st_d  = ST_ATTACK;
         cnt_d = '0;
      end else if (fall) begin
         st_d  = ST_RELEASE;
         cnt_d = '0;
      end else begin
         unique case (st_cur)
            ST_ATTACK: begin
               if (env_cur == ENV_MAX) begin
                  st_d  = ST_DECAY;
                  cnt_d = '0;
               end else if (tick) begin
                  cnt_d = '0;
                  env_d = env_cur + 8'd1;
                  if (env_cur == ENV_MAX - 8'd1) st_d = ST_DECAY;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_DECAY: begin
               if (env_cur <= sus_lvl) begin
                  st_d = ST_SUSTAIN;
               end else if (tick) begin
                  cnt_d = '0;
                  env_d = env_cur - 8'd1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_SUSTAIN: begin
               // Only a lowered sustain level moves the voice; a raised one never lifts env.
               if (env_cur > sus_lvl) st_d = ST_DECAY;
            end
            ST_RELEASE: begin
               if (env_cur != '0) begin
                  if (tick) begin
                     cnt_d = '0;
                     env_d = env_cur - 8'd1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
            end
            default: st_d = ST_RELEASE;
         endcase
      end
   end

   adsr_scale #(
      .WAVE_W (WAVE_W),
      .ENV_W  (ENV_W)
   ) u_scale (
      .wave_i   (bus.wave_i),
      .env_i    (env_d),
      .sample_o (scaled)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            env_q[v]  <= '0;
            st_q[v]   <= ST_RELEASE;
            cnt_q[v]  <= '0;
            gate_q[v] <= 1'b0;
         end
      end else if (upd) begin
         env_q[vidx]  <= env_d;
         st_q[vidx]   <= st_d;
         cnt_q[vidx]  <= cnt_d;
         gate_q[vidx] <= bus.gate_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bus.sample_valid_o <= 1'b0;
         bus.sample_voice_o <= '0;
         bus.sample_o       <= '0;
         bus.env_o          <= '0;
         bus.dbg_state      <= ST_RELEASE;
      end else begin
         bus.sample_valid_o <= upd;
         if (upd) begin
            bus.sample_voice_o <= bus.act_voice_i;
            bus.sample_o       <= scaled;
            bus.env_o          <= env_d;
            bus.dbg_state      <= st_d;
         end
      end
   end

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: attack/decay/sustain/release, retrigger, interleaving, reset.
// Builds with or without ENV_EXP_DECAY_EN; the release section adapts to the curve.
module tb_adsr_envelope;
   import adsr_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   steps;

   always #10 clk = ~clk;

   adsr_envelope_if #(.WAVE_W(10), .ENV_W(8)) env_bus ();

   adsr_envelope #(
      .NUM_VOICES (3),
      .WAVE_W     (10),
      .ENV_W      (8)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (env_bus)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // One update strobe; returns #1 after the capturing edge with the strobe dropped.
   task automatic upd(input logic [1:0] v, input logic g, input int w);
      env_bus.act_voice_i  = v;
      env_bus.gate_i       = g;
      env_bus.wave_i       = 10'(w);
      env_bus.wave_valid_i = 1'b1;
      @(posedge clk);
      #1;
      env_bus.wave_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      env_bus.wave_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      env_bus.wave_valid_i = 1'b0;
      env_bus.act_voice_i  = 2'd0;
      env_bus.wave_i       = '0;
      env_bus.gate_i       = 1'b0;
      env_bus.attack_i     = 4'd0;
      env_bus.decay_i      = 4'd0;
      env_bus.sustain_i    = 4'd8;
      env_bus.release_i    = 4'd0;
      do_reset();

      chk("rst_valid", env_bus.sample_valid_o, 0);
      chk("rst_voice", env_bus.sample_voice_o, 0);
      chk("rst_sample", env_bus.sample_o, 0);
      chk("rst_env", env_bus.env_o, 0);

      // Bring voice 0 into ATTACK at env=120, then reset on an update cycle.
      upd(2'd0, 1'b0, 511);
      upd(2'd0, 1'b1, 511);
      for (int i = 1; i <= 120; i++) upd(2'd0, 1'b1, 511);
      chk("pre_rst_env120", env_bus.env_o, 120);
      chk("pre_rst_attack", env_bus.dbg_state, ST_ATTACK);
      env_bus.act_voice_i  = 2'd0;
      env_bus.gate_i       = 1'b1;
      env_bus.wave_valid_i = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      env_bus.wave_valid_i = 1'b0;
      chk("midrst_valid", env_bus.sample_valid_o, 0);
      chk("midrst_sample", env_bus.sample_o, 0);
      chk("midrst_env", env_bus.env_o, 0);
      chk("midrst_voice", env_bus.sample_voice_o, 0);
      upd(2'd0, 1'b0, 511);
      chk("postrst_valid", env_bus.sample_valid_o, 1);
      chk("postrst_env", env_bus.env_o, 0);
      chk("postrst_sample", env_bus.sample_o, 0);

      // Attack at rate 0: edge update holds env, then +1 per update up to 255.
      upd(2'd0, 1'b1, 511);
      chk("atk_edge_env", env_bus.env_o, 0);
      chk("atk_edge_state", env_bus.dbg_state, ST_ATTACK);
      for (int i = 1; i <= 255; i++) begin
         upd(2'd0, 1'b1, 511);
         chk("atk_env", env_bus.env_o, i);
         if (i == 1) chk("atk_sample_first", env_bus.sample_o, 1);
      end
      chk("atk_sample_max", env_bus.sample_o, 509);
      chk("atk_to_decay", env_bus.dbg_state, ST_DECAY);

      // Decay at rate 0 (period 3) down to sustain level 0x88.
      for (int k = 1; k <= 357; k++) begin
         upd(2'd0, 1'b1, -512);
         chk("dec_env", env_bus.env_o, 255 - k / 3);
         if (k == 1) chk("dec_sample_neg_max", env_bus.sample_o, -510);
      end
      chk("dec_state_at_136", env_bus.dbg_state, ST_DECAY);
      for (int k = 0; k < 100; k++) begin
         upd(2'd0, 1'b1, -512);
         chk("sus_env", env_bus.env_o, 136);
      end
      chk("sus_sample", env_bus.sample_o, -272);
      chk("sus_state", env_bus.dbg_state, ST_SUSTAIN);

      // Release from 136.
      upd(2'd0, 1'b0, 511);
      chk("rel_edge_env", env_bus.env_o, 136);
      chk("rel_edge_state", env_bus.dbg_state, ST_RELEASE);
`ifdef ENV_EXP_DECAY_EN
      steps = 0;
      while (env_bus.env_o != 8'd6 && steps < 20000) begin
         upd(2'd0, 1'b0, 511);
         steps++;
      end
      chk("rel_reach6", env_bus.env_o, 6);
      steps = 0;
      while (env_bus.env_o == 8'd6 && steps < 200) begin
         upd(2'd0, 1'b0, 511);
         steps++;
      end
      chk("exp_period_90", steps, 90);
      chk("exp_env5", env_bus.env_o, 5);
      steps = 0;
      while (env_bus.env_o != 8'd0 && steps < 2000) begin
         upd(2'd0, 1'b0, 511);
         steps++;
      end
      chk("rel_zero", env_bus.env_o, 0);
`else
      for (int k = 1; k <= 408; k++) begin
         upd(2'd0, 1'b0, 511);
         chk("rel_env", env_bus.env_o, 136 - k / 3);
         if (k == 407) chk("rel_env_407", env_bus.env_o, 1);
      end
      chk("rel_zero_408", env_bus.env_o, 0);
`endif
      for (int k = 0; k < 5; k++) begin
         upd(2'd0, 1'b0, 511);
         chk("rel_hold0", env_bus.env_o, 0);
      end
      chk("rel_hold_sample", env_bus.sample_o, 0);

      // Retrigger from env=100 during release.
      upd(2'd0, 1'b1, 511);
      for (int i = 1; i <= 100; i++) upd(2'd0, 1'b1, 511);
      chk("rtg_env100", env_bus.env_o, 100);
      upd(2'd0, 1'b0, 511);
      chk("rtg_fall_env", env_bus.env_o, 100);
      chk("rtg_fall_state", env_bus.dbg_state, ST_RELEASE);
      upd(2'd0, 1'b1, 511);
      chk("rtg_rise_env", env_bus.env_o, 100);
      chk("rtg_rise_state", env_bus.dbg_state, ST_ATTACK);
      upd(2'd0, 1'b1, 511);
      chk("rtg_next_env", env_bus.env_o, 101);
      chk("rtg_next_state", env_bus.dbg_state, ST_ATTACK);

      // Round-robin with only voice 1 gated.
      do_reset();
      for (int r = 0; r <= 5; r++) begin
         upd(2'd0, 1'b0, 300);
         chk("rr_v0_voice", env_bus.sample_voice_o, 0);
         chk("rr_v0_env", env_bus.env_o, 0);
         upd(2'd1, 1'b1, 511);
         chk("rr_v1_voice", env_bus.sample_voice_o, 1);
         chk("rr_v1_env", env_bus.env_o, r);
         chk("rr_v1_sample", env_bus.sample_o, (511 * r) >>> 8);
         upd(2'd2, 1'b0, -300);
         chk("rr_v2_voice", env_bus.sample_voice_o, 2);
         chk("rr_v2_env", env_bus.env_o, 0);
         chk("rr_v2_valid", env_bus.sample_valid_o, 1);
      end

      // Voice index 3 is ignored entirely.
      upd(2'd3, 1'b1, 511);
      chk("v3_valid", env_bus.sample_valid_o, 0);
      chk("v3_voice_held", env_bus.sample_voice_o, 2);
      chk("v3_env_held", env_bus.env_o, 0);
      upd(2'd1, 1'b1, 511);
      chk("v3_v1_env", env_bus.env_o, 6);
      upd(2'd0, 1'b1, 511);
      chk("v3_v0_edge_env", env_bus.env_o, 0);
      chk("v3_v0_state", env_bus.dbg_state, ST_ATTACK);
      upd(2'd0, 1'b1, 511);
      chk("v3_v0_step", env_bus.env_o, 1);
      @(posedge clk);
      #1;
      chk("idle_valid_low", env_bus.sample_valid_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
